// File: rtl/init_done_sequencer.sv
// init_done_sequencer: synchronises and filters NUM_SRC asynchronous init/calibration
// status flags, waits for every required flag, then releases NUM_RST active-low resets
// one by one, STAGE_GAP cycles apart. It also detects timeouts, holds a sticky fault that
// records which sources caused it, and can optionally relock when a flag drops.
// Ports: CLK/RESET (async active-high), STATUS_IN raw flags, CLEAR_FAULT exit pulse,
//        STATUS_FILT filtered flags, ALL_DONE, RESET_N_OUT staged resets (bit 0 first),
//        FAULT, FAULT_SRC latched cause bits, STATE (WAIT=0 STAGE=1 READY=2 FAULT=3).
module init_done_sequencer #(
  parameter int                 NUM_SRC        = 4,
  parameter logic [NUM_SRC-1:0] REQ_MASK       = {NUM_SRC{1'b1}},
  parameter int                 FILT_CYCLES    = 4,
  parameter int                 NUM_RST        = 3,
  parameter int                 STAGE_GAP      = 8,
  parameter int                 TIMEOUT_CYCLES = 1024,
  parameter bit                 RELOCK_EN      = 1'b1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_SRC-1:0] STATUS_IN,
  input  logic               CLEAR_FAULT,
  output logic [NUM_SRC-1:0] STATUS_FILT,
  output logic               ALL_DONE,
  output logic [NUM_RST-1:0] RESET_N_OUT,
  output logic               FAULT,
  output logic [NUM_SRC-1:0] FAULT_SRC,
  output logic [1:0]         STATE
);

  localparam int FW = (FILT_CYCLES > 0)    ? $clog2(FILT_CYCLES + 1)    : 1;
  localparam int GW = (STAGE_GAP > 1)      ? $clog2(STAGE_GAP)          : 1;
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int SW = (NUM_RST > 1)        ? $clog2(NUM_RST)            : 1;

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_STAGE = 2'd1,
    S_READY = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  // Two-flop synchroniser for each status bit
  logic [NUM_SRC-1:0] sync1, sync2;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= STATUS_IN;
      sync2 <= sync1;
    end
  end

  // Per-bit filter. The bit rises slowly, after FILT_CYCLES consecutive high samples,
  // but falls on the very next edge after a single low sample.
  genvar i;
  generate
    for (i = 0; i < NUM_SRC; i++) begin : g_filt
      logic filt_q;
      assign STATUS_FILT[i] = filt_q;

      if (FILT_CYCLES == 0) begin : g_nofilt
        always_ff @(posedge CLK or posedge RESET) begin
          if (RESET) filt_q <= 1'b0;
          else       filt_q <= sync2[i];
        end
      end else begin : g_cnt
        logic [FW-1:0] cnt;
        always_ff @(posedge CLK or posedge RESET) begin
          if (RESET) begin
            cnt    <= '0;
            filt_q <= 1'b0;
          end else if (!sync2[i]) begin
            cnt    <= '0;
            filt_q <= 1'b0;
          end else if (cnt != FW'(FILT_CYCLES)) begin
            cnt <= cnt + FW'(1);
            if (cnt == FW'(FILT_CYCLES - 1)) filt_q <= 1'b1;
          end
        end
      end
    end
  endgenerate

  // Sources outside REQ_MASK are forced to "ok", so they never affect the sequencer
  logic req_ok;
  assign req_ok = &(STATUS_FILT | ~REQ_MASK);

  state_t        state;
  logic [TW-1:0] tcnt;
  logic [GW-1:0] gcnt;
  logic [SW-1:0] sidx;

  assign STATE = state;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= S_WAIT;
      tcnt        <= '0;
      gcnt        <= '0;
      sidx        <= '0;
      RESET_N_OUT <= '0;
      ALL_DONE    <= 1'b0;
      FAULT       <= 1'b0;
      FAULT_SRC   <= '0;
    end else begin
      case (state)
        S_WAIT: begin
          // If req_ok and the timeout happen in the same cycle, req_ok wins
          if (req_ok) begin
            state <= S_STAGE;
            gcnt  <= '0;
            sidx  <= '0;
          end else if (TIMEOUT_CYCLES != 0 && tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state     <= S_FAULT;
            FAULT     <= 1'b1;
            FAULT_SRC <= REQ_MASK & ~STATUS_FILT;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end

        S_STAGE, S_READY: begin
          if (!req_ok) begin
            RESET_N_OUT <= '0;
            ALL_DONE    <= 1'b0;
            if (RELOCK_EN) begin
              state <= S_WAIT;
              tcnt  <= '0;
            end else begin
              state     <= S_FAULT;
              FAULT     <= 1'b1;
              FAULT_SRC <= REQ_MASK & ~STATUS_FILT;
            end
          end else if (state == S_STAGE) begin
            if (gcnt == GW'(STAGE_GAP - 1)) begin
              RESET_N_OUT[sidx] <= 1'b1;
              gcnt              <= '0;
              sidx              <= sidx + SW'(1);
              // This edge releases the last reset, so ALL_DONE rises on it too
              if (sidx == SW'(NUM_RST - 1)) begin
                state    <= S_READY;
                ALL_DONE <= 1'b1;
              end
            end else begin
              gcnt <= gcnt + GW'(1);
            end
          end
        end

        S_FAULT: begin
          if (CLEAR_FAULT) begin
            state     <= S_WAIT;
            FAULT     <= 1'b0;
            FAULT_SRC <= '0;
            tcnt      <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_init_done_sequencer.sv
module tb_init_done_sequencer;

  localparam int         NS   = 4;
  localparam logic [3:0] MASK = 4'b1011;
  localparam int         FILT = 4;
  localparam int         NR   = 3;
  localparam int         GAP  = 8;
  localparam int         TO   = 64;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       CLEAR_FAULT;
  logic [3:0] STATUS_IN;

  // index 0: RELOCK_EN=1, index 1: RELOCK_EN=0; both share the same stimulus
  logic [3:0] st_filt  [2];
  logic       all_done [2];
  logic [2:0] rst_n    [2];
  logic       fault    [2];
  logic [3:0] fsrc     [2];
  logic [1:0] state    [2];

  init_done_sequencer #(.NUM_SRC(NS), .REQ_MASK(MASK), .FILT_CYCLES(FILT), .NUM_RST(NR),
                        .STAGE_GAP(GAP), .TIMEOUT_CYCLES(TO), .RELOCK_EN(1'b1)) dut_relock (
    .CLK(CLK), .RESET(RESET), .STATUS_IN(STATUS_IN), .CLEAR_FAULT(CLEAR_FAULT),
    .STATUS_FILT(st_filt[0]), .ALL_DONE(all_done[0]), .RESET_N_OUT(rst_n[0]),
    .FAULT(fault[0]), .FAULT_SRC(fsrc[0]), .STATE(state[0]));

  init_done_sequencer #(.NUM_SRC(NS), .REQ_MASK(MASK), .FILT_CYCLES(FILT), .NUM_RST(NR),
                        .STAGE_GAP(GAP), .TIMEOUT_CYCLES(TO), .RELOCK_EN(1'b0)) dut_nolock (
    .CLK(CLK), .RESET(RESET), .STATUS_IN(STATUS_IN), .CLEAR_FAULT(CLEAR_FAULT),
    .STATUS_FILT(st_filt[1]), .ALL_DONE(all_done[1]), .RESET_N_OUT(rst_n[1]),
    .FAULT(fault[1]), .FAULT_SRC(fsrc[1]), .STATE(state[1]));

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model.
  // Filter: a filtered bit is high iff the raw input was high at each of the FILT
  // sampling edges ending two edges ago (two edges are spent in the synchroniser).
  // Sequencer: phase plus the number of edges spent in that phase; the released-reset
  // count is derived from the phase age by division.
  logic [3:0] hist [6];     // hist[0] = input sampled at the latest edge
  logic [3:0] m_filt;
  int         m_phase [2];  // 0 wait, 1 stage, 2 ready, 3 fault
  int         m_age   [2];
  logic [3:0] m_src   [2];

  task automatic model_reset();
    for (int k = 0; k < 6; k++) hist[k] = 4'h0;
    m_filt = 4'h0;
    for (int d = 0; d < 2; d++) begin
      m_phase[d] = 0;
      m_age[d]   = 0;
      m_src[d]   = 4'h0;
    end
  endtask

  task automatic model_step();
    logic [3:0] f_old;
    logic [3:0] acc;
    logic       req;
    f_old = m_filt;
    req   = &(f_old | ~MASK);
    for (int d = 0; d < 2; d++) begin
      case (m_phase[d])
        0: begin
          m_age[d]++;
          if (req) begin
            m_phase[d] = 1;
            m_age[d]   = 0;
          end else if (m_age[d] == TO) begin
            m_phase[d] = 3;
            m_src[d]   = MASK & ~f_old;
          end
        end
        1, 2: begin
          if (!req) begin
            if (d == 0) begin
              m_phase[d] = 0;
              m_age[d]   = 0;
            end else begin
              m_phase[d] = 3;
              m_src[d]   = MASK & ~f_old;
            end
          end else if (m_phase[d] == 1) begin
            m_age[d]++;
            if (m_age[d] == NR * GAP) m_phase[d] = 2;
          end
        end
        default: begin
          if (CLEAR_FAULT) begin
            m_phase[d] = 0;
            m_age[d]   = 0;
            m_src[d]   = 4'h0;
          end
        end
      endcase
    end
    for (int k = 5; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = STATUS_IN;
    acc = 4'hF;
    for (int k = 2; k <= FILT + 1; k++) acc = acc & hist[k];
    m_filt = acc;
  endtask

  function automatic logic [2:0] exp_rst(input int d);
    int r;
    if (m_phase[d] == 2) return 3'b111;
    if (m_phase[d] == 1) begin
      r = m_age[d] / GAP;
      return 3'((1 << r) - 1);
    end
    return 3'b000;
  endfunction

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      check_val($sformatf("d%0d_filt", d),     32'(st_filt[d]),  32'(m_filt));
      check_val($sformatf("d%0d_state", d),    32'(state[d]),    32'(m_phase[d]));
      check_val($sformatf("d%0d_rst_n", d),    32'(rst_n[d]),    32'(exp_rst(d)));
      check_val($sformatf("d%0d_all_done", d), 32'(all_done[d]), 32'(m_phase[d] == 2));
      check_val($sformatf("d%0d_fault", d),    32'(fault[d]),    32'(m_phase[d] == 3));
      check_val($sformatf("d%0d_fault_src", d), 32'(fsrc[d]),    32'(m_src[d]));
    end
  endtask

  // One clock: step the model on the edge, check one time unit later
  task automatic do_cycle();
    @(posedge CLK);
    if (!RESET) model_step();
    #1;
    compare_all();
  endtask

  // Reset asserted between edges; the outputs must clear without waiting for a clock
  task automatic async_reset(input int hold);
    #3 RESET = 1'b1;
    #1;
    model_reset();
    compare_all();
    check_val("async_rst_n", 32'(rst_n[0]), 32'd0);
    repeat (hold) do_cycle();
    RESET = 1'b0;
  endtask

  logic [3:0] pat;

  initial begin
    RESET       = 1'b1;
    CLEAR_FAULT = 1'b0;
    STATUS_IN   = 4'h0;
    model_reset();
    #1;
    compare_all();
    repeat (2) do_cycle();
    RESET = 1'b0;

    // Required flags rise just after edge 0; bit 2 stays low and must not matter
    do_cycle();
    STATUS_IN = 4'b1011;
    for (int k = 1; k <= 34; k++) begin
      do_cycle();
      for (int d = 0; d < 2; d++) begin
        if (k == 5)  check_val("dir_filt_e5",  32'(st_filt[d]), 32'b0000);
        if (k == 6)  check_val("dir_filt_e6",  32'(st_filt[d]), 32'b1011);
        if (k == 6)  check_val("dir_state_e6", 32'(state[d]),   32'd0);
        if (k == 7)  check_val("dir_state_e7", 32'(state[d]),   32'd1);
        if (k == 14) check_val("dir_rst_e14",  32'(rst_n[d]),   32'b000);
        if (k == 15) check_val("dir_rst_e15",  32'(rst_n[d]),   32'b001);
        if (k == 23) check_val("dir_rst_e23",  32'(rst_n[d]),   32'b011);
        if (k == 30) check_val("dir_done_e30", 32'(all_done[d]), 32'd0);
        if (k == 31) check_val("dir_rst_e31",  32'(rst_n[d]),   32'b111);
        if (k == 31) check_val("dir_done_e31", 32'(all_done[d]), 32'd1);
        if (k == 31) check_val("dir_state_e31", 32'(state[d]),  32'd2);
      end
    end

    // Drop bit 1 in READY: relocking instance returns to WAIT, the other faults
    STATUS_IN = 4'b1001;
    for (int j = 1; j <= 5; j++) begin
      do_cycle();
      if (j == 3) check_val("drop_state_e3", 32'(state[0]), 32'd2);
      if (j == 4) begin
        check_val("drop_relock_state", 32'(state[0]), 32'd0);
        check_val("drop_relock_rst",   32'(rst_n[0]), 32'b000);
        check_val("drop_fault_state",  32'(state[1]), 32'd3);
        check_val("drop_fault_src",    32'(fsrc[1]),  32'b0010);
      end
    end
    STATUS_IN = 4'b1011;
    repeat (40) do_cycle();

    // Randomised segments: held patterns, one-cycle glitches, clear pulses, async resets
    for (int seg = 0; seg < 60; seg++) begin
      if ($urandom_range(9, 0) < 6) pat = 4'b1011 | 4'($urandom_range(1, 0) << 2);
      else                          pat = 4'($urandom_range(15, 0));
      for (int c = $urandom_range(90, 3); c > 0; c--) begin
        STATUS_IN   = pat;
        if ($urandom_range(19, 0) == 0) STATUS_IN = pat ^ 4'(1 << $urandom_range(3, 0));
        CLEAR_FAULT = ($urandom_range(11, 0) == 0);
        if ($urandom_range(299, 0) == 0) async_reset($urandom_range(2, 1));
        else do_cycle();
      end
    end
    CLEAR_FAULT = 1'b0;
    STATUS_IN   = 4'b1011;
    async_reset(1);
    repeat (40) do_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
